// File: rtl/booth_pkg.sv
// Shared types for the Booth operand feeder: issue FSM states and the operand pair.
package booth_pkg;
  localparam int W_DEF = 16;

  typedef enum logic [1:0] {IDLE, START, LOAD, WAIT_DONE} state_e;

  typedef struct packed {
    logic [W_DEF-1:0] mcand;
    logic [W_DEF-1:0] mplier;
  } op_pair_t;
endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous FIFO for operand pairs; the caller never pushes when full or pops when empty.
module booth_op_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/booth_operand_feeder.sv
// Issue stage for the Booth multiplier: queues operand pairs, runs one job at a time
// over the shared data_in bus, and retires on done or on a watchdog timeout.
module booth_operand_feeder
  import booth_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4*W+8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_mcand,
  input  logic [W-1:0]            in_mplier,
  output logic                    mult_start,
  input  logic                    mult_ldm,
  input  logic                    mult_ldq,
  input  logic                    mult_done,
  output logic [W-1:0]            data_in,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    timeout_err
);
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     mc_h_q, mp_h_q;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             err_q, err_d;
  logic             push, pop, load_h, full, empty;
  logic [2*W-1:0]   head;

  booth_op_fifo #(.DEPTH(DEPTH), .DW(2*W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_mcand, in_mplier}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Gated by rst_n so upstream sees not-ready for the whole reset window.
  assign in_ready    = rst_n & ~full;
  assign push        = in_valid & in_ready;
  assign mult_start  = (state_q == START);
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    pop     = 1'b0;
    load_h  = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        state_d = START;
        load_h  = 1'b1;
      end
      START: state_d = LOAD;
      LOAD: if (mult_ldq) begin
        state_d = WAIT_DONE;
        wd_d    = '0;
      end
      WAIT_DONE: begin
        // done wins over a coincident timeout
        if (mult_done) begin
          pop     = 1'b1;
          wd_d    = '0;
          state_d = IDLE;
        end else if (wd_q == WD_LAST) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          wd_d    = '0;
          state_d = IDLE;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_in = mc_h_q;
    if (state_q == LOAD && mult_ldq) data_in = mp_h_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mc_h_q  <= '0;
      mp_h_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      if (load_h) begin
        mc_h_q <= head[2*W-1:W];
        mp_h_q <= head[W-1:0];
      end
    end
  end
endmodule
